branch_redirect_ctrl: RTL
=========================

Name: branch_redirect_ctrl

Overview:
Execute-stage control-flow resolution controller. It consumes the branch comparator's taken flag with the execute-stage operands and computes the architectural next PC. It checks that PC against the fetch-stage prediction. On mismatch it sequences the pipeline flush and the redirect handshake to fetch, stalling execute until recovery completes.

Parameters:
XLEN, 32, datapath/PC width
FLUSH_CYCLES, 2, cycles flush is held high per mispredict; legal range 1..7

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
ex_valid  input  1  execute stage holds a valid instruction
ex_is_branch  input  1  conditional branch (B-type)
ex_is_jal  input  1  JAL
ex_is_jalr  input  1  JALR
ex_pc  input  XLEN  PC of execute instruction
ex_imm  input  XLEN  sign-extended immediate
ex_rs1_val  input  XLEN  rs1 operand, used by JALR
ex_pred_pc  input  XLEN  next PC predicted by fetch
br_taken  input  1  branch comparator result, valid when ex_is_branch
ex_ready  output  1  execute may retire its instruction; 0 stalls execute
flush  output  1  kill IF/ID contents
redirect_valid  output  1  redirect request to fetch
redirect_pc  output  XLEN  redirect target
redirect_ready  input  1  fetch accepts redirect
misaligned_exc  output  1  one-cycle pulse: taken target not 4-byte aligned
busy  output  1  FSM not in IDLE
branch_cnt  output  32  resolved control-flow count (feature only)
mispredict_cnt  output  32  mispredict count (feature only)

Behaviour:
- Reset values:
  - state=IDLE; ex_ready=1; flush=0; redirect_valid=0; redirect_pc=0; misaligned_exc=0; busy=0; counters=0.
  - rst overrides any in-flight flush or redirect and returns to IDLE next edge.
- Resolve condition: IDLE & ex_valid & (ex_is_branch|ex_is_jal|ex_is_jalr).
  - Non-control-flow instructions are ignored.
- Next-PC computation, all arithmetic mod 2^XLEN:
  - taken = jal | jalr | (is_branch & br_taken).
  - target = jalr ? ((rs1+imm) & ~1) : (pc+imm).
  - next_pc = taken ? target : pc+4.
- If more than one of is_branch/is_jal/is_jalr is set, priority is jalr > jal > branch.
- FSM states: IDLE, FLUSH, REDIRECT.
- IDLE:
  - ex_ready=1.
  - Resolve & taken & target[1:0]!=0: misaligned_exc=1 for the next cycle only; no flush, no redirect; stay IDLE.
  - Else resolve & next_pc!=ex_pred_pc: latch redirect_pc=next_pc, load counter=FLUSH_CYCLES, go to FLUSH.
  - Else (correct prediction): stay IDLE.
- FLUSH:
  - flush=1, ex_ready=0, busy=1.
  - Counter decrements each cycle; at 1 → REDIRECT. flush is high exactly FLUSH_CYCLES cycles.
- REDIRECT:
  - redirect_valid=1, ex_ready=0, busy=1.
  - redirect_pc is stable while redirect_valid=1 and redirect_ready=0.
  - On redirect_valid & redirect_ready at an edge: go to IDLE; redirect_valid=0 next cycle.
- Handshake rules:
  - redirect_ready is ignored outside REDIRECT.
  - redirect_valid never drops without a handshake, except on rst.
- New resolves are not taken outside IDLE. Upstream holds the instruction because ex_ready=0.
- Mispredict-to-IDLE latency: the mispredict cycle, FLUSH_CYCLES cycles of flush, then ≥1 REDIRECT cycle.
- Back-to-back: the first cycle in IDLE after a handshake may immediately resolve a new branch.
- All outputs are registered except ex_ready, which is a decode of state.

Optional Feature:
BRC_STATS_EN:
- Defined:
  - branch_cnt increments on every resolve that is not misaligned.
  - mispredict_cnt increments on each IDLE→FLUSH transition.
  - Both are 32-bit, wrap at 2^32, and are cleared by rst.
- Undefined: both ports are driven constant 0 and no counter flops are synthesized.

Test Plan:
- BEQ taken, pc=0x100, imm=0x20, br_taken=1, pred=0x120 → no flush, ex_ready stays 1, redirect_valid never asserts.
- BNE not taken, pc=0x200, br_taken=0, pred=0x240 → flush high 2 cycles; then redirect_valid=1 with redirect_pc=0x204, held 3 cycles with ready=0; on handshake return to IDLE.
- JALR rs1=0x1001, imm=0x10, pred=0 → redirect_pc=0x1010 (bit0 cleared); JAL pc=0x300, imm=0x6 → misaligned_exc pulses 1 cycle, no flush.
- rst asserted in cycle 2 of REDIRECT → next cycle state=IDLE, redirect_valid=0, ex_ready=1, counters=0.
- Wrap: pc=0xFFFFFFFC, not-taken branch, pred=0 → no mispredict (pc+4 wraps to 0); pc=0xFFFFFFF0, imm=0x20, taken → target 0x10.
- BRC_STATS_EN: 5 branches with 2 mispredicts → branch_cnt=5, mispredict_cnt=2; with macro undefined, both read 0.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: execute-stage next-PC resolution, flush and fetch redirect sequencing (BRC_STATS_EN adds counters)
module branch_redirect_ctrl #(
  parameter int XLEN = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1_val,
  input  logic [XLEN-1:0] ex_pred_pc,
  input  logic            br_taken,
  output logic            ex_ready,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            misaligned_exc,
  output logic            busy,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispredict_cnt
);
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
  state_t state;
  logic [2:0] cnt;
  logic resolve, taken, mis, mp;
  logic [XLEN-1:0] target, next_pc;
  always_comb begin
    resolve = state == IDLE && ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr);
    taken = ex_is_jalr || ex_is_jal || (ex_is_branch && br_taken);
    target = ex_is_jalr ? ((ex_rs1_val + ex_imm) & ~XLEN'(1)) : ex_pc + ex_imm;
    next_pc = taken ? target : ex_pc + XLEN'(4);
    mis = taken && target[1:0] != 2'b00;
    mp = resolve && !mis && next_pc != ex_pred_pc;
  end
  assign ex_ready = state == IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      flush <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      misaligned_exc <= 1'b0;
      busy <= 1'b0;
    end else begin
      misaligned_exc <= resolve && mis;
      case (state)
        IDLE: if (mp) begin
          state <= FLUSH;
          cnt <= 3'(FLUSH_CYCLES);
          redirect_pc <= next_pc;
          flush <= 1'b1;
          busy <= 1'b1;
        end
        FLUSH: if (cnt == 3'd1) begin
          state <= REDIRECT;
          flush <= 1'b0;
          redirect_valid <= 1'b1;
        end else cnt <= cnt - 3'd1;
        REDIRECT: if (redirect_ready) begin
          state <= IDLE;
          redirect_valid <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef BRC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (resolve && !mis) branch_cnt <= branch_cnt + 32'd1;
      if (mp) mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end
`else
  assign branch_cnt = '0;
  assign mispredict_cnt = '0;
`endif
endmodule
